// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and data-memory bus bundle for the lsu
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        busy;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata, busy,
        output mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, busy,
        input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - RV64 load/store unit; optional LSU_RANGE_CHECK_EN adds data-window range faults
module lsu #(
    parameter logic [63:0] MEM_BASE       = 64'h0000_0000_8000_0000,
    parameter logic [63:0] MEM_SIZE       = 64'h0000_0000_0800_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus_io
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_t;

    localparam logic [64:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || MEM_SIZE == 64'd0 || MEM_END[64]) begin : g_bad_cfg
        $error("lsu: invalid configuration");
    end

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic        misaligned;
    logic        range_fault;
    logic        timeout;
    logic [63:0] load_sh;
    logic [63:0] load_ext;
    logic [7:0]  lane_mask;
    logic        resp_valid;

    always_comb begin
        misaligned = 1'b0;
        case (bus_io.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus_io.req_addr[0];
            2'd2:    misaligned = |bus_io.req_addr[1:0];
            default: misaligned = |bus_io.req_addr[2:0];
        endcase
    end

`ifdef LSU_RANGE_CHECK_EN
    logic [3:0]  size_bytes;
    logic [64:0] acc_end;
    assign size_bytes  = 4'd1 << bus_io.req_size;
    assign acc_end     = {1'b0, bus_io.req_addr} + 65'(size_bytes);
    assign range_fault = (bus_io.req_addr < MEM_BASE) || (acc_end > MEM_END);
`else
    assign range_fault = 1'b0;
`endif

    // The cycle that would bring the counter to the limit is the last one allowed
    assign timeout = ({1'b0, cnt_q} + 17'd1) >= TO_LIMIT;

    assign load_sh = bus_io.mem_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = load_sh;
        case (size_q)
            2'd0:    load_ext = unsigned_q ? {56'd0, load_sh[7:0]}  : {{56{load_sh[7]}},  load_sh[7:0]};
            2'd1:    load_ext = unsigned_q ? {48'd0, load_sh[15:0]} : {{48{load_sh[15]}}, load_sh[15:0]};
            2'd2:    load_ext = unsigned_q ? {32'd0, load_sh[31:0]} : {{32{load_sh[31]}}, load_sh[31:0]};
            default: load_ext = load_sh;
        endcase
    end

    always_comb begin
        lane_mask = 8'h00;
        case (size_q)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            cnt_q      <= 16'd0;
            err_q      <= 1'b0;
            rdata_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus_io.req_valid) begin
                    write_d    = bus_io.req_write;
                    size_d     = bus_io.req_size;
                    unsigned_d = bus_io.req_unsigned;
                    addr_d     = bus_io.req_addr;
                    wdata_d    = bus_io.req_wdata;
                    cnt_d      = 16'd0;
                    rdata_d    = 64'd0;
                    err_d      = misaligned || range_fault;
                    state_d    = (misaligned || range_fault) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                // A handshake in the final allowed cycle still counts as progress
                if (bus_io.mem_ready) begin
                    state_d = write_q ? S_RESP : S_WAIT_R;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_io.mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign resp_valid        = (state_q == S_RESP) && !rst;
    assign bus_io.resp_valid = resp_valid;
    assign bus_io.resp_err   = resp_valid && err_q;
    assign bus_io.resp_rdata = resp_valid ? rdata_q : 64'd0;
    assign bus_io.req_ready  = (state_q == S_IDLE) && !rst;
    assign bus_io.busy       = (state_q != S_IDLE) && !rst;
    assign bus_io.mem_valid  = (state_q == S_REQ) && !rst;
    assign bus_io.mem_write  = write_q;
    assign bus_io.mem_addr   = {addr_q[63:3], 3'b000};
    assign bus_io.mem_wdata  = wdata_q << {addr_q[2:0], 3'b000};
    assign bus_io.mem_wmask  = lane_mask << addr_q[2:0];
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the RV64 single-cycle core and the data-memory bus. Accepts one load or store request at a time from the core's execute stage. Converts it into an 8-byte-aligned bus transaction with byte lanes and write mask, and returns sign- or zero-extended load data. Holds the core stalled while busy, and faults misaligned, out-of-range and timed-out accesses without hanging the core.

## Interface
- MEM_BASE, 64'h0000000080000000, lowest legal data address
- MEM_SIZE, 64'h0000000008000000, legal window size in bytes
- TIMEOUT_CYCLES, 255, maximum bus wait cycles before fault (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept; high only in IDLE and not in reset
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU); ignored for size 3 and stores
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_err  out  1  valid with resp_valid: misaligned, range or timeout fault
- resp_rdata  out  64  extended load data; 0 for stores and faults
- busy  out  1  high from accept until the resp_valid cycle inclusive (core stall)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_write  out  1  bus write
- mem_addr  out  64  {req_addr[63:3], 3'b000}
- mem_wdata  out  64  req_wdata << (8*req_addr[2:0])
- mem_wmask  out  8  size mask (1, 3, F, FF hex) << req_addr[2:0]
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  aligned read data

## Operation
- States:
  - IDLE: `req_ready` high.
    - `req_valid` high: latch all request fields.
    - Fault check, then go to RESP with error on fault, else go to REQ.
  - REQ: `mem_valid` high; bus outputs are stable from the latched request.
    - `mem_valid && mem_ready`: stores go to RESP, loads go to WAIT_R.
  - WAIT_R: wait for `mem_rvalid`.
    - Capture `mem_rdata`, then go to RESP.
  - RESP: `resp_valid` high for one cycle, then IDLE.
- Faults, detected at accept; no bus traffic on a fault:
  - misaligned: `req_addr & ((1<<req_size)-1) != 0`.
  - range fault: see Configuration.
- Load extraction:
  - shift: `sh = mem_rdata >> (8*addr[2:0])`.
  - take the low `1<<size` bytes of `sh`.
  - sign-extend from the top bit unless `req_unsigned`; size 3 is passed through unchanged.
- Timeout:
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches `TIMEOUT_CYCLES`: go to RESP with `resp_err=1`, drop `mem_valid`.
- `mem_rvalid` outside WAIT_R is ignored; this includes late data after a timeout.
- Store `resp_rdata` = 0.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - all of `mem_valid`, `resp_valid`, `resp_err`, `resp_rdata`, `busy` = 0.
  - `req_ready` = 0 during the `rst` cycle, 1 on the first cycle after.
- Accept cycle T, i.e. `req_valid && req_ready`.
  - Fault case: `resp_valid` at T+1.
  - Store with `mem_ready` high immediately: `mem_valid` at T+1, `resp_valid` at T+2.
  - Load: `mem_rvalid` is legal no earlier than the cycle after the bus handshake; the earliest `resp_valid` is T+3.
- Throughput: the next request can be accepted the cycle after `resp_valid`.
- `rst` mid-transaction aborts the transaction:
  - `mem_valid` is 0 the next cycle.
  - No `resp_valid` is issued.
  - Pending bus data is ignored.
- Bus outputs must not change while `mem_valid && !mem_ready`.

## Configuration
- `LSU_RANGE_CHECK_EN`:
  - Defined: accesses where `req_addr < MEM_BASE` or `req_addr + (1<<size) > MEM_BASE + MEM_SIZE` fault at accept, with no bus traffic.
  - Undefined: no range check; only misalignment and timeout produce `resp_err`.

## Test plan
- Load word, signed:
  - Stimulus: addr 0x80000004, size 2, signed; `mem_rdata` 0x8765432100000000.
  - Required: `mem_addr` 0x80000000, `resp_rdata` 0xFFFFFFFF87654321, `resp_valid` at T+3 with zero-wait bus.
- Store byte:
  - Stimulus: addr 0x80000003, wdata 0xAB, `mem_ready` held low 3 cycles.
  - Required: `mem_wmask` 0x08, `mem_wdata` 0xAB000000; outputs stable while waiting; `resp_valid` with `resp_err` 0.
- Misaligned load:
  - Stimulus: half at addr 0x80000001.
  - Required: no `mem_valid`, `resp_valid` + `resp_err` at T+1, `resp_rdata` 0.
- Load byte, unsigned:
  - Stimulus: addr 0x80000007, `mem_rdata` 0xF0000000_00000000, `req_unsigned`=1.
  - Required: `resp_rdata` 0xF0.
  - Repeat signed: required `resp_rdata` 0xFFFFFFFFFFFFFFF0.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=4, load, `mem_ready`=1, `mem_rvalid` never asserted.
  - Required: `resp_err` pulse after 4 wait cycles.
  - Follow-up: a later stray `mem_rvalid` is ignored and the next request completes normally.
- Range check, with `LSU_RANGE_CHECK_EN` defined:
  - Stimulus: addr 0x7FFFFFF8, size 3.
  - Required: fault, no bus traffic.
- Reset mid-transaction:
  - Stimulus: `rst` during WAIT_R.
  - Required: no `resp_valid`; `req_ready`=1 the cycle after `rst` drops.
